// File: rtl/ternary_serial_adder.sv
// ternary_serial_adder
//   Multi-digit unsigned ternary adder/subtractor. One binary-coded trit is
//   processed per clock, least significant first, with a registered carry.
//   Subtraction adds the digit-wise complement (2 - b) with a carry-in of 1.
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : operation request, sampled only while busy = 0
//   sub        : 0 = a + b, 1 = a - b (latched with start)
//   a, b       : operands, trit i = [2i+1:2i], trit 0 least significant
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   sum        : result trits, same packing as the operands
//   cout       : add: carry out; sub: 1 = no borrow (a >= b)
//   err        : sticky flag, an illegal trit code (2'b11) was processed
module ternary_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [2*DIGITS-1:0]   a,
  input  logic [2*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = 2 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_d, done_d, cout_d, err_d;
  logic [W-1:0]     sum_d;

  // Single-trit datapath for the digit selected by idx_q
  logic [IDX_W:0] bit_pos;
  logic [1:0]     x_raw, y_raw;
  logic           x_ill, y_ill;
  logic [1:0]     x_val, y_val, y_eff;
  logic [2:0]     t_full;
  logic           t_ge3;
  logic [1:0]     t_mod;
  logic [W-1:0]   trit_mask;
  logic [W-1:0]   sum_upd;

  always_comb begin
    bit_pos   = {idx_q, 1'b0};
    x_raw     = 2'(a_q >> bit_pos);
    y_raw     = 2'(b_q >> bit_pos);
    x_ill     = (x_raw == 2'b11);
    y_ill     = (y_raw == 2'b11);
    // Illegal codes are flagged and then treated as trit value 0
    x_val     = x_ill ? 2'd0 : x_raw;
    y_val     = y_ill ? 2'd0 : y_raw;
    y_eff     = sub_q ? 2'(2'd2 - y_val) : y_val;
    t_full    = 3'(x_val) + 3'(y_eff) + 3'(carry_q);
    t_ge3     = (t_full >= 3'd3);
    t_mod     = t_ge3 ? 2'(t_full - 3'd3) : 2'(t_full);
    trit_mask = W'(2'b11) << bit_pos;
    sum_upd   = (sum & ~trit_mask) | (W'(t_mod) << bit_pos);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy;
    done_d  = 1'b0;
    sum_d   = sum;
    cout_d  = cout;
    err_d   = err;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = sum_upd;
        carry_d = t_ge3;
        idx_d   = idx_q + IDX_W'(1);
        if (x_ill || y_ill) begin
          err_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = t_ge3;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
      sum     <= sum_d;
      cout    <= cout_d;
      err     <= err_d;
    end
  end

endmodule
